// File: rtl/audio_clk_pkg.sv
// Shared types and constants for the audio clock generator.
// Holds the tuning-word FSM states, dither LFSR constants and divider legality check.
package audio_clk_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } tw_state_e;

  // Galois LFSR, taps 16,14,13,11 mapped onto a right-shifting register
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic bit div_ok(input int d);
    return (d >= 2) && ((d % 2) == 0);
  endfunction

endpackage

// File: rtl/audio_clk_gen_clk_div_even.sv
// Even integer divider driven by a single-cycle tick; out toggles every DIV/2 ticks.
// rise/fall flag the tick on which out is about to change, so callers can chain dividers with no lag.
module clk_div_even
  import audio_clk_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_in,
  output logic out,
  output logic rise,
  output logic fall
);

  localparam int HALF = DIV / 2;
  localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);

  if (!div_ok(DIV)) begin : g_bad_div
    $error("clk_div_even: DIV must be even and at least 2");
  end

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             out_reg, out_next;
  logic             wrap;

  always_comb begin
    wrap     = tick_in && (cnt_reg == CNT_LAST);
    cnt_next = cnt_reg;
    out_next = out_reg;
    if (wrap) begin
      cnt_next = '0;
      out_next = ~out_reg;
    end else if (tick_in) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
      out_reg <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      out_reg <= out_next;
    end
  end

  assign out  = out_reg;
  assign rise = wrap & ~out_reg;
  assign fall = wrap & out_reg;

endmodule

// File: rtl/audio_clk_gen.sv
// DDS-based MCLK generator with I2S BCLK/LRCK dividers and a glitch-free tuning-word update.
// Optional macro AUDIO_CLK_DITHER_EN adds LFSR dither to the accumulator increment.
module audio_clk_gen
  import audio_clk_pkg::*;
#(
  parameter int          ACC_W         = 64,
  parameter logic [63:0] TW_DEFAULT    = 64'd4165090344402879488,
  parameter int          MCLK_PER_BCLK = 4,
  parameter int          BCLK_PER_LRCK = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [ACC_W-1:0] tw_in,
  input  logic             tw_valid,
  output logic             tw_ready,
  output logic [ACC_W-1:0] tw_active,
  output logic             mclk,
  output logic             mclk_rise,
  output logic             bclk,
  output logic             lrck,
  output logic             frame_start
);

  localparam logic [ACC_W-1:0] TW_RESET = TW_DEFAULT[ACC_W-1:0];

  if (ACC_W < 8 || ACC_W > 64) begin : g_bad_acc_w
    $error("audio_clk_gen: ACC_W must be within 8..64");
  end

  logic [ACC_W-1:0] acc_reg, acc_next, incr;
  logic [ACC_W-1:0] tw_active_reg, tw_active_next;
  logic [ACC_W-1:0] pend_tw_reg, pend_tw_next;
  tw_state_e        tw_state_reg, tw_state_next;
  logic             mclk_rise_reg, frame_start_reg;
  logic             rise_next, fall_carry, apply_now;
  logic             bclk_fall, lrck_fall;
  logic             bclk_rise_unused, lrck_rise_unused;

`ifdef AUDIO_CLK_DITHER_EN
  logic [15:0] lfsr_reg, lfsr_shift;

  for (genvar gi = 0; gi < 16; gi++) begin : g_lfsr
    if (gi == 15) begin : g_top
      assign lfsr_shift[gi] = LFSR_TAPS[gi] & lfsr_reg[0];
    end else begin : g_mid
      assign lfsr_shift[gi] = lfsr_reg[gi+1] ^ (LFSR_TAPS[gi] & lfsr_reg[0]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         lfsr_reg <= LFSR_SEED;
    else if (enable) lfsr_reg <= lfsr_shift;
  end

  assign incr = tw_active_reg + {{(ACC_W-4){1'b0}}, lfsr_reg[3:0]};
`else
  assign incr = tw_active_reg;
`endif

  always_comb begin
    acc_next   = enable ? (acc_reg + incr) : acc_reg;
    rise_next  = enable & ~acc_reg[ACC_W-1] & acc_next[ACC_W-1];
    fall_carry = enable & acc_reg[ACC_W-1] & ~acc_next[ACC_W-1];
    // A zero word or a stalled accumulator never produces a falling edge, so apply at once.
    apply_now  = fall_carry | ~enable | (tw_active_reg == '0);
  end

  always_comb begin
    tw_state_next  = tw_state_reg;
    pend_tw_next   = pend_tw_reg;
    tw_active_next = tw_active_reg;
    tw_ready       = 1'b0;
    case (tw_state_reg)
      IDLE: begin
        tw_ready = 1'b1;
        if (tw_valid) begin
          pend_tw_next  = tw_in;
          tw_state_next = PENDING;
        end
      end
      PENDING: begin
        if (apply_now) begin
          tw_active_next = pend_tw_reg;
          tw_state_next  = IDLE;
        end
      end
      default: tw_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg         <= '0;
      tw_active_reg   <= TW_RESET;
      pend_tw_reg     <= '0;
      tw_state_reg    <= IDLE;
      mclk_rise_reg   <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      acc_reg         <= acc_next;
      tw_active_reg   <= tw_active_next;
      pend_tw_reg     <= pend_tw_next;
      tw_state_reg    <= tw_state_next;
      mclk_rise_reg   <= rise_next;
      frame_start_reg <= lrck_fall;
    end
  end

  // Ticks are the combinational edge events, so divider outputs register on the same edge.
  clk_div_even #(.DIV(MCLK_PER_BCLK)) u_bclk_div (
    .clk     (clk),
    .rst     (rst),
    .tick_in (rise_next),
    .out     (bclk),
    .rise    (bclk_rise_unused),
    .fall    (bclk_fall)
  );

  clk_div_even #(.DIV(BCLK_PER_LRCK)) u_lrck_div (
    .clk     (clk),
    .rst     (rst),
    .tick_in (bclk_fall),
    .out     (lrck),
    .rise    (lrck_rise_unused),
    .fall    (lrck_fall)
  );

  assign mclk        = acc_reg[ACC_W-1];
  assign tw_active   = tw_active_reg;
  assign mclk_rise   = mclk_rise_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_audio_clk_gen.sv
// Scoreboard bench for audio_clk_gen (ACC_W=8, TW=64, 4 MCLK/BCLK, 4 BCLK/LRCK).
// A behavioural model pushes the expected output snapshot each cycle; tests pop and compare.
module tb_audio_clk_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] tw_in = 8'd0;
  logic       tw_valid = 1'b0;
  logic       tw_ready;
  logic [7:0] tw_active;
  logic       mclk, mclk_rise, bclk, lrck, frame_start;

  audio_clk_gen #(
    .ACC_W(8), .TW_DEFAULT(64'd64), .MCLK_PER_BCLK(4), .BCLK_PER_LRCK(4)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .tw_in(tw_in), .tw_valid(tw_valid),
    .tw_ready(tw_ready), .tw_active(tw_active), .mclk(mclk), .mclk_rise(mclk_rise),
    .bclk(bclk), .lrck(lrck), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef logic [13:0] snap_t;
  snap_t sb_q[$];
  snap_t exp_s;
  int    n_cmp = 0;
  int    n_fail = 0;
  int    cyc = 0;

  // Model: mclk edges from the accumulator, dividers from the count of mclk rises.
  logic [7:0] m_acc, m_tw, m_pend;
  bit         m_pending, m_rise, m_fs;
  int         m_rises;

  function automatic snap_t dut_snap();
    return {tw_ready, tw_active, mclk, mclk_rise, bclk, lrck, frame_start};
  endfunction

  function automatic bit m_bclk();
    return ((m_rises / 2) % 2) == 1;
  endfunction

  function automatic bit m_lrck();
    return ((m_rises / 8) % 2) == 1;
  endfunction

  task automatic model_step();
    logic [7:0] nacc;
    bit         rise, fallc, old_l;
    if (rst) begin
      m_acc = 8'd0; m_tw = 8'd64; m_pend = 8'd0; m_pending = 0;
      m_rises = 0; m_rise = 0; m_fs = 0;
    end else begin
      nacc  = enable ? m_acc + m_tw : m_acc;
      rise  = enable && !m_acc[7] && nacc[7];
      fallc = enable && m_acc[7] && !nacc[7];
      if (m_pending) begin
        if (fallc || !enable || m_tw == 8'd0) begin
          m_tw = m_pend; m_pending = 0;
          $display("txn apply  cyc=%0d tw=%0d", cyc + 1, m_tw);
        end
      end else if (tw_valid) begin
        m_pend = tw_in; m_pending = 1;
        $display("txn accept cyc=%0d tw=%0d", cyc + 1, tw_in);
      end
      old_l = m_lrck();
      if (rise) m_rises++;
      m_fs   = old_l && !m_lrck();
      m_rise = rise;
      m_acc  = nacc;
    end
    sb_q.push_back({!m_pending, m_tw, m_acc[7], m_rise, m_bclk(), m_lrck(), m_fs});
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_s = sb_q.pop_front(); n_cmp++;
      if (dut_snap() !== exp_s) begin
        n_fail++; $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, dut_snap(), exp_s);
      end
    end
    n_cmp++;
    if (tw_active !== 8'd64 || tw_ready !== 1'b1 || frame_start !== 1'b0 || mclk !== 1'b0) begin
      n_fail++; $display("FAIL reset_vals got tw=%0d rdy=%b fs=%b mclk=%b exp tw=64 rdy=1 fs=0 mclk=0",
                         tw_active, tw_ready, frame_start, mclk);
    end
    rst = 1'b0;
  endtask

  task automatic test_mclk_period();
    int last_rise = -1, last_brise = -1, last_fs = -1;
    bit prev_b = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      exp_s = sb_q.pop_front(); n_cmp++;
      if (dut_snap() !== exp_s) begin
        n_fail++; $display("FAIL period cyc=%0d got=%h exp=%h", cyc, dut_snap(), exp_s);
      end
      if (mclk_rise === 1'b1) begin
        if (last_rise >= 0) begin
          n_cmp++;
          if (cyc - last_rise != 4) begin
            n_fail++; $display("FAIL mclk_period got=%0d exp=4", cyc - last_rise);
          end
        end
        last_rise = cyc;
      end
      if (bclk === 1'b1 && !prev_b) begin
        if (last_brise >= 0) begin
          n_cmp++;
          if (cyc - last_brise != 16) begin
            n_fail++; $display("FAIL bclk_period got=%0d exp=16", cyc - last_brise);
          end
        end
        last_brise = cyc;
      end
      prev_b = (bclk === 1'b1);
      if (frame_start === 1'b1) begin
        if (last_fs >= 0) begin
          n_cmp++;
          if (cyc - last_fs != 64) begin
            n_fail++; $display("FAIL lrck_period got=%0d exp=64", cyc - last_fs);
          end
        end
        last_fs = cyc;
      end
    end
  endtask

  task automatic test_handshake();
    int  hi_run = 0;
    bit  started = 0;
    for (int i = 0; i < 8 && !m_acc[7]; i++) begin
      tick();
      exp_s = sb_q.pop_front(); n_cmp++;
      if (dut_snap() !== exp_s) begin
        n_fail++; $display("FAIL hs_wait cyc=%0d got=%h exp=%h", cyc, dut_snap(), exp_s);
      end
    end
    tw_valid = 1'b1; tw_in = 8'd32;
    tick();
    exp_s = sb_q.pop_front(); n_cmp++;
    if (dut_snap() !== exp_s) begin
      n_fail++; $display("FAIL hs_accept cyc=%0d got=%h exp=%h", cyc, dut_snap(), exp_s);
    end
    tw_valid = 1'b0;
    n_cmp++;
    if (tw_ready !== 1'b0) begin
      n_fail++; $display("FAIL hs_ready_low got=%b exp=0", tw_ready);
    end
    for (int i = 0; i < 24; i++) begin
      tick();
      exp_s = sb_q.pop_front(); n_cmp++;
      if (dut_snap() !== exp_s) begin
        n_fail++; $display("FAIL hs_run cyc=%0d got=%h exp=%h", cyc, dut_snap(), exp_s);
      end
      if (mclk === 1'b1) begin
        if (started) hi_run++;
      end else begin
        if (started && hi_run > 0) begin
          n_cmp++;
          if (hi_run < 2) begin
            n_fail++; $display("FAIL hs_runt got=%0d exp>=2", hi_run);
          end
        end
        started = 1; hi_run = 0;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seen[$];
    logic [7:0] prev_tw = tw_active;
    int         accepts = 0;
    bit         done = 0;
    tw_valid = 1'b1; tw_in = 8'd64;
    for (int i = 0; i < 60 && !done; i++) begin
      if (!m_pending && tw_valid) accepts++;
      tick();
      exp_s = sb_q.pop_front(); n_cmp++;
      if (dut_snap() !== exp_s) begin
        n_fail++; $display("FAIL b2b cyc=%0d got=%h exp=%h", cyc, dut_snap(), exp_s);
      end
      if (tw_active !== prev_tw) seen.push_back(tw_active);
      prev_tw = tw_active;
      if (accepts == 1) tw_in = 8'd16;
      if (accepts == 2) tw_valid = 1'b0;
      done = (accepts == 2) && !m_pending;
    end
    tw_valid = 1'b0;
    n_cmp++;
    if (!done) begin
      n_fail++; $display("FAIL b2b_timeout got=accepts %0d exp=2 applied", accepts);
    end
    n_cmp++;
    if (seen.size() != 2 || seen[0] !== 8'd64 || seen[1] !== 8'd16) begin
      n_fail++; $display("FAIL b2b_order got=%0d changes first=%0d exp=64 then 16",
                         seen.size(), (seen.size() > 0) ? seen[0] : 8'd0);
    end
  endtask

  task automatic test_enable_freeze();
    logic [2:0] frz;
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_s = sb_q.pop_front(); n_cmp++;
      if (dut_snap() !== exp_s) begin
        n_fail++; $display("FAIL frz_pre cyc=%0d got=%h exp=%h", cyc, dut_snap(), exp_s);
      end
    end
    tw_valid = 1'b1; tw_in = 8'd64;
    tick();
    exp_s = sb_q.pop_front(); n_cmp++;
    if (dut_snap() !== exp_s) begin
      n_fail++; $display("FAIL frz_accept cyc=%0d got=%h exp=%h", cyc, dut_snap(), exp_s);
    end
    tw_valid = 1'b0; enable = 1'b0;
    frz = {mclk, bclk, lrck};
    for (int i = 0; i < 10; i++) begin
      tick();
      exp_s = sb_q.pop_front(); n_cmp++;
      if (dut_snap() !== exp_s) begin
        n_fail++; $display("FAIL frz_hold cyc=%0d got=%h exp=%h", cyc, dut_snap(), exp_s);
      end
      if (i == 0) begin
        n_cmp++;
        if (tw_active !== 8'd64) begin
          n_fail++; $display("FAIL frz_apply got=%0d exp=64", tw_active);
        end
      end
    end
    n_cmp++;
    if ({mclk, bclk, lrck} !== frz) begin
      n_fail++; $display("FAIL frz_levels got=%b exp=%b", {mclk, bclk, lrck}, frz);
    end
    enable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      exp_s = sb_q.pop_front(); n_cmp++;
      if (dut_snap() !== exp_s) begin
        n_fail++; $display("FAIL frz_resume cyc=%0d got=%h exp=%h", cyc, dut_snap(), exp_s);
      end
    end
  endtask

  task automatic test_tw_zero();
    tw_valid = 1'b1; tw_in = 8'd0;
    tick();
    exp_s = sb_q.pop_front(); n_cmp++;
    if (dut_snap() !== exp_s) begin
      n_fail++; $display("FAIL zero_accept cyc=%0d got=%h exp=%h", cyc, dut_snap(), exp_s);
    end
    tw_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      exp_s = sb_q.pop_front(); n_cmp++;
      if (dut_snap() !== exp_s) begin
        n_fail++; $display("FAIL zero_hold cyc=%0d got=%h exp=%h", cyc, dut_snap(), exp_s);
      end
    end
    tw_valid = 1'b1; tw_in = 8'd64;
    tick();
    exp_s = sb_q.pop_front(); n_cmp++;
    if (dut_snap() !== exp_s) begin
      n_fail++; $display("FAIL zero_reload cyc=%0d got=%h exp=%h", cyc, dut_snap(), exp_s);
    end
    tw_valid = 1'b0;
    tick();
    exp_s = sb_q.pop_front(); n_cmp++;
    if (dut_snap() !== exp_s) begin
      n_fail++; $display("FAIL zero_apply cyc=%0d got=%h exp=%h", cyc, dut_snap(), exp_s);
    end
    n_cmp++;
    if (tw_active !== 8'd64 || tw_ready !== 1'b1) begin
      n_fail++; $display("FAIL zero_unstick got tw=%0d rdy=%b exp tw=64 rdy=1", tw_active, tw_ready);
    end
  endtask

  task automatic test_reset_pending();
    bit found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      tick();
      exp_s = sb_q.pop_front(); n_cmp++;
      if (dut_snap() !== exp_s) begin
        n_fail++; $display("FAIL rp_wait cyc=%0d got=%h exp=%h", cyc, dut_snap(), exp_s);
      end
      found = m_bclk();
    end
    n_cmp++;
    if (!found) begin
      n_fail++; $display("FAIL rp_timeout got=bclk %b exp=1", bclk);
    end
    tw_valid = 1'b1; tw_in = 8'd32;
    tick();
    exp_s = sb_q.pop_front(); n_cmp++;
    if (dut_snap() !== exp_s) begin
      n_fail++; $display("FAIL rp_accept cyc=%0d got=%h exp=%h", cyc, dut_snap(), exp_s);
    end
    tw_valid = 1'b0; rst = 1'b1;
    tick();
    exp_s = sb_q.pop_front(); n_cmp++;
    if (dut_snap() !== exp_s) begin
      n_fail++; $display("FAIL rp_reset cyc=%0d got=%h exp=%h", cyc, dut_snap(), exp_s);
    end
    n_cmp++;
    if (tw_active !== 8'd64 || tw_ready !== 1'b1 || bclk !== 1'b0 || lrck !== 1'b0) begin
      n_fail++; $display("FAIL rp_vals got tw=%0d rdy=%b bclk=%b lrck=%b exp tw=64 rdy=1 bclk=0 lrck=0",
                         tw_active, tw_ready, bclk, lrck);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      exp_s = sb_q.pop_front(); n_cmp++;
      if (dut_snap() !== exp_s) begin
        n_fail++; $display("FAIL rp_after cyc=%0d got=%h exp=%h", cyc, dut_snap(), exp_s);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mclk_period();
    test_handshake();
    test_back_to_back();
    test_enable_freeze();
    test_tw_zero();
    test_reset_pending();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=cycle %0d exp=bench finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/audio_clk_gen.md
Name: audio_clk_gen

Overview:
Parametrised successor to the fixed-word MCLK DDS. A phase accumulator generates MCLK, and integer dividers on MCLK derive I2S BCLK and LRCK plus a frame strobe. The tuning word is programmable at runtime through a valid/ready handshake and is applied glitch-free on an MCLK falling edge. The block sits between the system clock domain and the codec/ADC serial interface.

Parameters:
ACC_W, 64, phase accumulator width; range 8..64.
TW_DEFAULT, 64'd4165090344402879488, tuning word loaded at reset; truncated to ACC_W.
MCLK_PER_BCLK, 4, MCLK periods per BCLK period; must be even and ≥2.
BCLK_PER_LRCK, 64, BCLK periods per LRCK period; must be even and ≥2.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enable  in  1  accumulator advance enable
tw_in  in  ACC_W  new tuning word
tw_valid  in  1  tw_in valid
tw_ready  out  1  block can accept a tuning word
tw_active  out  ACC_W  tuning word currently in use
mclk  out  1  master clock (accumulator MSB)
mclk_rise  out  1  one-cycle pulse, the first cycle mclk reads 1
bclk  out  1  bit clock
lrck  out  1  word select; 0 = left channel
frame_start  out  1  one-cycle pulse when lrck falls 1→0

Behaviour:
- Reset (clk, rst synchronous active-high) values:
  - acc=0, tw_active=TW_DEFAULT, tw_ready=1.
  - mclk=0, bclk=0, lrck=0, mclk_rise=0, frame_start=0.
  - All counters 0, pending-word state cleared.
  - Reset mid-handshake discards the pending word.
- Accumulator:
  - When enable=1: acc <= acc + tw_active, modulo 2^ACC_W.
  - mclk = acc[ACC_W-1], taken directly from the register with no extra latency.
  - When enable=0: acc and all dividers hold; outputs are frozen.
- mclk_rise is registered and coincides with the first cycle mclk=1.
- Tuning-word FSM:
  - IDLE: tw_ready=1. On tw_valid & tw_ready, capture tw_in into pend_tw and go to PENDING.
  - PENDING: tw_ready=0. Apply pend_tw to tw_active in the cycle where the accumulator update carries the MSB 1→0 (MCLK falling edge). The new word is used from the next add. Return to IDLE, so tw_ready=1 the cycle after the apply.
  - If enable=0 while PENDING, apply on the next clk.
  - If tw_active=0 while PENDING, apply on the next clk so the block cannot deadlock.
  - Accept and apply never coincide.
- BCLK divider:
  - Counter of mclk_rise pulses; bclk toggles every MCLK_PER_BCLK/2 pulses.
  - The toggle registers in the same cycle as the mclk_rise pulse, i.e. the first cycle mclk=1.
- LRCK divider:
  - Counter of bclk falling edges; lrck toggles every BCLK_PER_LRCK/2 falls, in the same cycle as the bclk fall.
  - frame_start asserts for exactly 1 clk in the cycle lrck becomes 0. It does not assert at reset.
- Tuning-word rules:
  - tw=0: mclk holds its current level, dividers stall, no pulses.
  - tw ≥ 2^(ACC_W-1): accepted without checking; aliasing is the user's responsibility.

Optional Feature:
AUDIO_CLK_DITHER_EN
- Defined: a 16-bit Galois LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances when enable=1. Its low 4 bits are added to the accumulator increment, giving acc <= acc + tw_active + lfsr[3:0]. This spreads fractional-spur energy; tw_active is reported unmodified.
- Undefined: no LFSR logic; pure acc + tw_active.

Decomposition:
- Package audio_clk_pkg holds:
  - The tw_state_e enum (IDLE, PENDING).
  - LFSR seed and tap constants.
  - The divider-legality check function used by an elaboration-time assertion (even, ≥2).
- Natural sub-module: clk_div_even (parameter DIV; ports clk, rst, tick_in, out, rise, fall), instantiated twice for BCLK and LRCK.

Test Plan:
- ACC_W=8, reset, tw_active=8'd64, enable=1 → mclk period 4 clk, duty 2/2; mclk_rise every 4 clk; with MCLK_PER_BCLK=4, bclk period 16 clk.
- BCLK_PER_LRCK=4, run 200 clk → lrck period 4 bclk = 64 clk; frame_start 1-clk pulse each lrck 1→0; none at reset.
- Handshake while mclk=1: send tw=8'd32 → tw_ready=0 the next cycle; tw_active changes only in the 1→0 carry cycle; tw_ready=1 one cycle later; no mclk high pulse shorter than the old half-period.
- tw_valid held across PENDING with a second word 8'd16 → second word accepted only after tw_ready returns; both applied in order on successive falling edges.
- enable=0 for 10 clk mid-period → acc, mclk, bclk and lrck frozen; pending word applies within 1 clk; resume is phase-continuous.
- rst pulsed while PENDING with bclk=1 → all outputs at reset values next cycle; tw_active=TW_DEFAULT; pending word discarded.
